key_event_src: RTL and testbench

//  Producer side of the push-button path. Turns the raw asynchronous KEY[] lines

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce.sv | 56 +++++
 rtl/key_event_src.sv | 181 ++++++++++++++++++
 tb/tb_key_event_src.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared event codes, repeat-FSM states and the queued event record
// used by the key event path.
package key_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RATE  = 2'd2
    } rep_state_t;

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] kind;
    } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, debounce counter and debounced level.
// rise/fall pulse during the cycle whose closing edge flips the level.
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s;

    assign s     = ~sync_q[1];
    assign state = state_q;

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d = s;
            cnt_d   = '0;
            rise    = s;
            fall    = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_src.sv
// Push-button event source: per-key debounce, shared auto-repeat timer,
// pending-bit arbiter and a small event FIFO read over valid/ready.
module key_event_src
    import key_pkg::*;
#(
    parameter int NKEYS        = 4,
    parameter int DEB_CYCLES   = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [2:0]       ev_code,
    output logic [1:0]       ev_kind,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic [NKEYS-1:0] rise, fall;

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clock   (clock),
            .reset_n (reset_n),
            .key_n   (key_n[k]),
            .state   (key_state[k]),
            .rise    (rise[k]),
            .fall    (fall[k])
        );
    end

    rep_state_t       st_q, st_d;
    logic [KW-1:0]    rk_q, rk_d, first_rise;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [NKEYS-1:0] rep_set;

    // A new press always re-arms the timer; otherwise only a release of rk disarms it.
    always_comb begin
        first_rise = '0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (rise[k]) first_rise = KW'(k);
        end
        st_d    = st_q;
        rk_d    = rk_q;
        tmr_d   = tmr_q;
        rep_set = '0;
        if (|rise) begin
            st_d  = ST_DELAY;
            rk_d  = first_rise;
            tmr_d = TW'(REPEAT_DELAY - 1);
        end else if (st_q != ST_IDLE && fall[rk_q]) begin
            st_d  = ST_IDLE;
            tmr_d = '0;
        end else begin
            case (st_q)
                ST_DELAY, ST_RATE: begin
                    if (tmr_q == '0) begin
                        rep_set[rk_q] = 1'b1;
                        st_d          = ST_RATE;
                        tmr_d         = TW'(REPEAT_RATE - 1);
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                default: tmr_d = '0;
            endcase
        end
    end

    logic [NKEYS-1:0] press_q, press_d, rel_q, rel_d, rep_q, rep_d;
    logic [NKEYS-1:0] press_clr, rel_clr, rep_clr;
    logic             pick_valid;
    logic [KW-1:0]    pick_key;
    logic [1:0]       pick_kind;
    logic             arb_valid_q, arb_valid_d;
    key_event_t       arb_ev_q, arb_ev_d;

    always_comb begin
        pick_valid = 1'b0;
        pick_key   = '0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (press_q[k] | rel_q[k] | rep_q[k]) begin
                pick_valid = 1'b1;
                pick_key   = KW'(k);
            end
        end
        press_clr = '0;
        rel_clr   = '0;
        rep_clr   = '0;
        if (press_q[pick_key]) begin
            pick_kind           = EV_PRESS;
            press_clr[pick_key] = pick_valid;
        end else if (rel_q[pick_key]) begin
            pick_kind         = EV_RELEASE;
            rel_clr[pick_key] = pick_valid;
        end else begin
            pick_kind         = EV_REPEAT;
            rep_clr[pick_key] = pick_valid;
        end
        press_d     = (press_q & ~press_clr) | rise;
        rel_d       = (rel_q & ~rel_clr) | fall;
        rep_d       = (rep_q & ~rep_clr) | rep_set;
        arb_valid_d = pick_valid;
        arb_ev_d    = '{code: 3'(pick_key), kind: pick_kind};
    end

    key_event_t      mem_q [FIFO_DEPTH];
    key_event_t      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            pop, push, drop, full;

    // A full FIFO still takes the event when the head leaves in the same cycle.
    always_comb begin
        full       = (count_q == CNTW'(FIFO_DEPTH));
        pop        = valid_q & ev_ready;
        push       = arb_valid_q & (~full | pop);
        drop       = arb_valid_q & full & ~pop;
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = arb_ev_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CNTW'(push) - CNTW'(pop);
        valid_d    = (count_d != '0);
        overflow_d = drop | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= ST_IDLE;
            rk_q        <= '0;
            tmr_q       <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            rep_q       <= '0;
            arb_valid_q <= 1'b0;
            arb_ev_q    <= '0;
            // NOTE: the queue storage is reset too, so the head outputs read as zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            rk_q        <= rk_d;
            tmr_q       <= tmr_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            rep_q       <= rep_d;
            arb_valid_q <= arb_valid_d;
            arb_ev_q    <= arb_ev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ev_valid = valid_q;
    assign ev_code  = mem_q[rd_ptr_q].code;
    assign ev_kind  = mem_q[rd_ptr_q].kind;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_src.sv
// Bench for key_event_src: table of debounce vectors, hand-written repeat/arbiter/
// overflow/reset sequences, and a random run against an event-level reference model.
module tb_key_event_src;

    localparam int NK  = 4;
    localparam int DEB = 8;
    localparam int RD  = 40;
    localparam int RR  = 16;
    localparam int K_PRESS = 0, K_RELEASE = 1, K_REPEAT = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state;
    logic          ev_valid, ev_ready, overflow, ovf_clr;
    logic [2:0]    ev_code;
    logic [1:0]    ev_kind;

    key_event_src #(
        .NKEYS(NK), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .key_n     (key_n),
        .key_state (key_state),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_kind   (ev_kind),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clock = ~clock;

    typedef struct { int code; int kind; int cyc; } ev_t;
    typedef struct { int key; int hold; bit press; } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ev_t  got[$];
    ev_t  exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1)
            got.push_back('{code: int'(ev_code), kind: int'(ev_kind), cyc: cyc});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_ev(input string name, input int idx, input int code, input int kind);
        if (idx < got.size()) begin
            check({name, " code"}, got[idx].code, code);
            check({name, " kind"}, got[idx].kind, kind);
        end else begin
            check({name, " present"}, got.size(), idx + 1);
        end
    endtask

    // Reference model: debounced level = s held opposite for DEB consecutive samples;
    // repeats fall due at fixed edge times after the latest press.
    logic [NK-1:0]  m_kd1, m_kd2, m_state, m_pp, m_pr, m_prep;
    logic [DEB-1:0] m_hist [NK];
    bit             m_armed;
    int             m_rk, m_next, m_edge;

    task automatic model_reset();
        m_kd1 = '1; m_kd2 = '1; m_state = '0;
        m_pp = '0; m_pr = '0; m_prep = '0;
        for (int k = 0; k < NK; k++) m_hist[k] = '0;
        m_armed = 0; m_rk = 0; m_next = 0; m_edge = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [NK-1:0] kn);
        logic [NK-1:0] s, rise, fall, rep;
        bit picked;
        m_edge++;
        s = ~m_kd2;
        m_kd2 = m_kd1;
        m_kd1 = kn;
        rise = '0; fall = '0; rep = '0;
        for (int k = 0; k < NK; k++) begin
            m_hist[k] = {m_hist[k][DEB-2:0], s[k]};
            if (!m_state[k] && m_hist[k] == '1) rise[k] = 1'b1;
            if (m_state[k] && m_hist[k] == '0) fall[k] = 1'b1;
        end
        m_state = m_state ^ (rise | fall);
        picked = 0;
        for (int k = 0; k < NK; k++) begin
            if (!picked) begin
                if (m_pp[k]) begin
                    exp_q.push_back('{code: k, kind: K_PRESS, cyc: m_edge}); m_pp[k] = 1'b0; picked = 1;
                end else if (m_pr[k]) begin
                    exp_q.push_back('{code: k, kind: K_RELEASE, cyc: m_edge}); m_pr[k] = 1'b0; picked = 1;
                end else if (m_prep[k]) begin
                    exp_q.push_back('{code: k, kind: K_REPEAT, cyc: m_edge}); m_prep[k] = 1'b0; picked = 1;
                end
            end
        end
        if (rise != '0) begin
            for (int k = NK - 1; k >= 0; k--) if (rise[k]) m_rk = k;
            m_armed = 1;
            m_next  = m_edge + RD;
        end else if (m_armed && fall[m_rk]) begin
            m_armed = 0;
        end else if (m_armed && m_edge == m_next) begin
            rep[m_rk] = 1'b1;
            m_next    = m_next + RR;
        end
        m_pp   = m_pp | rise;
        m_pr   = m_pr | fall;
        m_prep = m_prep | rep;
    endtask

    vec_t vecs[6];
    int   t3_kind [6] = '{K_PRESS, K_REPEAT, K_REPEAT, K_REPEAT, K_REPEAT, K_RELEASE};
    int   t3_off  [5] = '{0, 40, 56, 72, 88};
    int   hc [NK];

    initial begin
        vecs[0] = '{key: 2, hold: 6,  press: 0};
        vecs[1] = '{key: 1, hold: 30, press: 1};
        vecs[2] = '{key: 3, hold: 7,  press: 0};
        vecs[3] = '{key: 0, hold: 8,  press: 1};
        vecs[4] = '{key: 2, hold: 1,  press: 0};
        vecs[5] = '{key: 3, hold: 12, press: 1};

        reset_n = 1'b0; key_n = '1; ev_ready = 1'b1; ovf_clr = 1'b0;
        #3;
        check("reset key_state", key_state, 0);
        check("reset ev_valid", ev_valid, 0);
        check("reset ev_code", ev_code, 0);
        check("reset ev_kind", ev_kind, 0);
        check("reset overflow", overflow, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Debounce table: a low pulse shorter than DEB never registers.
        foreach (vecs[i]) begin
            bit saw;
            saw = 0;
            got.delete();
            key_n[vecs[i].key] = 1'b0;
            repeat (vecs[i].hold) begin
                tick();
                if (key_state[vecs[i].key]) saw = 1;
            end
            key_n[vecs[i].key] = 1'b1;
            repeat (40) begin
                tick();
                if (key_state[vecs[i].key]) saw = 1;
            end
            check($sformatf("vec%0d level seen", i), saw, vecs[i].press);
            check($sformatf("vec%0d event count", i), got.size(), vecs[i].press ? 2 : 0);
            if (vecs[i].press) begin
                check_ev($sformatf("vec%0d press", i), 0, vecs[i].key, K_PRESS);
                check_ev($sformatf("vec%0d release", i), 1, vecs[i].key, K_RELEASE);
            end
            check($sformatf("vec%0d final level", i), key_state, 0);
        end

        // Latency and auto-repeat on key 0.
        got.delete();
        key_n[0] = 1'b0;
        tick(9);
        check("t3 level before accept", key_state[0], 0);
        tick(1);
        check("t3 level at accept", key_state[0], 1);
        tick(1);
        check("t3 valid before latency", ev_valid, 0);
        tick(1);
        check("t3 valid at latency", ev_valid, 1);
        tick(83);
        key_n[0] = 1'b1;
        tick(40);
        check("t3 event count", got.size(), 6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++) check_ev($sformatf("t3 ev%0d", i), i, 0, t3_kind[i]);
            for (int i = 1; i < 5; i++)
                check($sformatf("t3 repeat%0d offset", i), got[i].cyc - got[0].cyc, t3_off[i]);
        end

        // Simultaneous presses: key 0 wins arbitration and owns the repeats.
        got.delete();
        key_n[0] = 1'b0; key_n[3] = 1'b0;
        tick(55);
        key_n = '1;
        tick(40);
        check("t4 event count", got.size(), 5);
        check_ev("t4 first", 0, 0, K_PRESS);
        check_ev("t4 second", 1, 3, K_PRESS);
        if (got.size() >= 2) check("t4 back to back", got[1].cyc - got[0].cyc, 1);
        check_ev("t4 repeat", 2, 0, K_REPEAT);
        check_ev("t4 rel0", 3, 0, K_RELEASE);
        check_ev("t4 rel3", 4, 3, K_RELEASE);

        // Overflow: six events into a stalled four-entry queue.
        got.delete();
        ev_ready = 1'b0;
        key_n[0] = 1'b0; key_n[1] = 1'b0; key_n[2] = 1'b0;
        tick(20);
        check("t5 overflow with 3 queued", overflow, 0);
        key_n = '1;
        tick(20);
        check("t5 overflow set", overflow, 1);
        check("t5 head valid", ev_valid, 1);
        check("t5 head code", ev_code, 0);
        check("t5 head kind", ev_kind, K_PRESS);
        ev_ready = 1'b1;
        tick(10);
        check("t5 pops", got.size(), 4);
        check_ev("t5 q0", 0, 0, K_PRESS);
        check_ev("t5 q1", 1, 1, K_PRESS);
        check_ev("t5 q2", 2, 2, K_PRESS);
        check_ev("t5 q3", 3, 0, K_RELEASE);
        check("t5 drained", ev_valid, 0);
        check("t5 overflow sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5 overflow cleared", overflow, 0);

        // Reset in the middle of a repeat with two events queued.
        ev_ready = 1'b0;
        key_n[2] = 1'b0;
        tick(55);
        check("t6 queued before reset", ev_valid, 1);
        reset_n = 1'b0;
        #1;
        check("t6 valid in reset", ev_valid, 0);
        check("t6 level in reset", key_state, 0);
        tick(1);
        reset_n  = 1'b1;
        ev_ready = 1'b1;
        got.delete();
        tick(9);
        check("t6 level before accept", key_state[2], 0);
        tick(1);
        check("t6 level at accept", key_state[2], 1);
        tick(5);
        check("t6 event count", got.size(), 1);
        check_ev("t6 press", 0, 2, K_PRESS);
        key_n = '1;
        tick(30);

        // Random glitches and holds against the reference model.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        model_reset();
        got.delete();
        for (int k = 0; k < NK; k++) hc[k] = $urandom_range(1, 20);
        for (int c = 0; c < 3000; c++) begin
            tick();
            model_edge(key_n);
            check("rnd key_state", key_state, m_state);
            for (int k = 0; k < NK; k++) begin
                if (hc[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    hc[k] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 7) : $urandom_range(8, 70);
                end else begin
                    hc[k]--;
                end
            end
        end
        key_n = '1;
        for (int c = 0; c < 60; c++) begin
            tick();
            model_edge(key_n);
            check("rnd drain key_state", key_state, m_state);
        end
        check("rnd event count", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("rnd event%0d code*4+kind", i),
                  got[i].code * 4 + got[i].kind, exp_q[i].code * 4 + exp_q[i].kind);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
